fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage 16-bit pipeline. Owns the PC, drives the instruction-memory handshake, and holds the IF/ID pipeline register. Feeds the hazard unit: `instr` is the freshly fetched word it inspects, and `FD_instr` is the IF/ID word it compares against. The hazard unit's bubble request stalls this stage; downstream branch/jump resolution redirects it.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC loaded on reset
- NOP_INSTR, 16'h0800, bubble encoding inserted into IF/ID

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit bubble request: hold PC and the fetched word, and load a bubble into IF/ID
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  16  target PC for `redirect`
- imem_req  out  1  memory read request
- imem_addr  out  16  read address (= PC)
- imem_rdata  in  16  read data, valid when `imem_done`
- imem_done  in  1  read complete this cycle
- instr  out  16  current fetched word (buffered or `imem_rdata`), `NOP_INSTR` when none
- FD_instr  out  16  IF/ID instruction
- FD_pc_inc  out  16  IF/ID PC+2
- FD_valid  out  1  IF/ID holds a real instruction
- halted  out  1  HALT fetched and accepted
- err  out  1  sticky misaligned-PC error

## Operation
- States:
  - FETCH: `imem_req`=1, `imem_addr`=pc.
  - WAIT: an access is outstanding; `imem_req` is held at 1.
  - HALT: `imem_req`=0.
- A fetched word comes from `imem_done`=1 or from the valid buffer `ibuf`. It is *accepted* when `stall`=0 and `redirect`=0.
- On accept:
  - FD_instr ← word, FD_pc_inc ← pc+2, FD_valid ← 1.
  - pc ← pc+2, with 16-bit wrap (16'hFFFE → 16'h0000). Clear `ibuf`.
- If a word is available but `stall`=1, the word goes into `ibuf`. No new request is issued while `ibuf` is valid.
- If no word is available (FETCH with `imem_done`=0): go to WAIT, FD_instr ← NOP_INSTR, FD_valid ← 0.
- WAIT returns to FETCH behaviour on `imem_done`.
- Priority is redirect > stall > accept.
- Redirect:
  - pc ← redirect_pc, FD_instr ← NOP_INSTR, FD_valid ← 0, clear `ibuf`.
  - If in WAIT, set `drop`. The outstanding response is discarded when `imem_done` arrives, then the stage goes to FETCH.
- HALT entry: an accepted word with [15:11]=5'b00000 is a HALT. It is still loaded into IF/ID, `halted` ← 1, state ← HALT.
- While in HALT, IF/ID loads NOP_INSTR.
- Redirect while in HALT means the HALT was speculative: `halted` ← 0, state ← FETCH, pc ← redirect_pc.
- Misaligned PC: if pc[0]=1 in FETCH, then `err` ← 1 (sticky until reset), no request is made, and state ← HALT.
- Stall with no word available has no extra effect; the stage behaves as waiting.

## Timing
- Reset values (asynchronous):
  - pc=RESET_PC, state=FETCH.
  - FD_instr=NOP_INSTR, FD_pc_inc=0, FD_valid=0.
  - halted=0, err=0, `ibuf` invalid, `drop`=0.
  - `imem_req`=0 while `rst`=1.
- The first request is issued in the first cycle after `rst` deasserts.
- With a zero-wait memory (`imem_done` in the request cycle), the word appears in FD_instr at the next clock edge. Throughput is 1 instruction per cycle.
- An N-wait access costs N bubbles in IF/ID.
- `instr` is combinational from `ibuf`/`imem_rdata`. All other outputs are registered.
- Reset asserted mid-access abandons the access. A late `imem_done` after reset is ignored unless a request is outstanding.
- Simultaneous `redirect` and `imem_done` in WAIT: the data is dropped, and pc takes redirect_pc.

## Structure
- Shared pipeline package:
  - OP_HALT=5'b00000, OP_NOP=5'b00001, NOP_INSTR=16'h0800.
  - fetch state enum {FETCH, WAIT, HALT}.
- One sub-module: `if_id_reg`, the IF/ID register with load/bubble controls and async reset to NOP. The decode/ID-EX registers reuse it.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning 16'h4001, 16'h4002, 16'h4003 → FD_instr follows one per cycle; pc goes 2, 4, 6; FD_pc_inc goes 2, 4, 6.
- `stall`=1 for 2 cycles while 16'h4002 is fetched → FD_instr=16'h0800 for 2 cycles, then 16'h4002. pc holds at 2. No second request while `ibuf` is valid.
- 3-wait memory → 3 bubbles (FD_valid=0, FD_instr=16'h0800), then the word. `imem_req` stays high through WAIT.
- `redirect`=1, redirect_pc=16'h0100 during WAIT → late data is dropped, next `imem_addr`=16'h0100, IF/ID holds NOP.
- Fetch 16'h0000 → `halted`=1, `imem_req`=0 thereafter. A later `redirect` to 16'h0020 clears `halted` and resumes fetching at 16'h0020.
- redirect_pc=16'h0003 → `err`=1 with no request issued; redirect_pc=16'hFFFE → next pc wraps to 16'h0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: opcode fields, bubble encoding and fetch states.
package fetch_stage_pkg;

    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [4:0]  OP_NOP    = 5'b00001;
    localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load/bubble controls; a bubble replaces the word with NOP.
module if_id_reg #(
    parameter int            W   = 16,
    parameter logic [W-1:0]  NOP = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         bubble,
    input  logic [W-1:0] next_instr,
    input  logic [W-1:0] next_pc_inc,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc_inc,
    output logic         valid
);

    // Load wins over bubble; a bubble keeps pc_inc so it tracks the last real word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr  <= NOP;
            pc_inc <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            instr  <= next_instr;
            pc_inc <= next_pc_inc;
            valid  <= 1'b1;
        end else if (bubble) begin
            instr  <= NOP;
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory handshake, one-word stall buffer and IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] FD_instr,
    output logic [15:0] FD_pc_inc,
    output logic        FD_valid,
    output logic        halted,
    output logic        err
);
    import fetch_stage_pkg::*;

    fetch_state_t state_reg, state_next;
    logic [15:0]  pc_reg, pc_next;
    logic [15:0]  ibuf_reg, ibuf_next;
    logic         ibuf_valid_reg, ibuf_valid_next;
    logic         drop_reg, drop_next;
    logic         halted_reg, halted_next;
    logic         err_reg, err_next;

    logic         issue, misaligned, mem_hit, avail, fd_load;
    logic [15:0]  word;

    // A request goes out only from FETCH with an aligned PC and an empty buffer.
    always_comb begin
        misaligned = (state_reg == FETCH) && pc_reg[0];
        issue      = (state_reg == FETCH) && !ibuf_valid_reg && !pc_reg[0] && !rst;
        imem_req   = issue || ((state_reg == WAIT) && !rst);
        mem_hit    = imem_done && (issue || ((state_reg == WAIT) && !drop_reg));
        avail      = (state_reg != HALT) && (ibuf_valid_reg || mem_hit);
        word       = ibuf_valid_reg ? ibuf_reg : imem_rdata;
        instr      = avail ? word : NOP_INSTR;
    end

    assign imem_addr = pc_reg;
    assign halted    = halted_reg;
    assign err       = err_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ibuf_next       = ibuf_reg;
        ibuf_valid_next = ibuf_valid_reg;
        drop_next       = drop_reg;
        halted_next     = halted_reg;
        err_next        = err_reg;
        fd_load         = 1'b0;

        if (state_reg == HALT) begin
            // A redirect here means the HALT was on a mispredicted path.
            if (redirect) begin
                pc_next     = redirect_pc;
                halted_next = 1'b0;
                state_next  = FETCH;
            end
        end else if (redirect) begin
            pc_next         = redirect_pc;
            ibuf_valid_next = 1'b0;
            if (imem_req && !imem_done) begin
                state_next = WAIT;
                drop_next  = 1'b1;
            end else begin
                state_next = FETCH;
                drop_next  = 1'b0;
            end
        end else if (misaligned) begin
            err_next   = 1'b1;
            state_next = HALT;
        end else if (avail) begin
            if (stall) begin
                ibuf_next       = word;
                ibuf_valid_next = 1'b1;
                state_next      = FETCH;
            end else begin
                fd_load         = 1'b1;
                pc_next         = pc_reg + 16'd2;
                ibuf_valid_next = 1'b0;
                if (is_halt(word)) begin
                    halted_next = 1'b1;
                    state_next  = HALT;
                end else begin
                    state_next = FETCH;
                end
            end
        end else if (issue) begin
            state_next = WAIT;
        end else if ((state_reg == WAIT) && imem_done) begin
            // Discarded response of an access that a redirect overtook.
            drop_next  = 1'b0;
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            ibuf_reg       <= '0;
            ibuf_valid_reg <= 1'b0;
            drop_reg       <= 1'b0;
            halted_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ibuf_reg       <= ibuf_next;
            ibuf_valid_reg <= ibuf_valid_next;
            drop_reg       <= drop_next;
            halted_reg     <= halted_next;
            err_reg        <= err_next;
        end
    end

    if_id_reg #(
        .W   (16),
        .NOP (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (fd_load),
        .bubble      (!fd_load),
        .next_instr  (word),
        .next_pc_inc (pc_reg + 16'd2),
        .instr       (FD_instr),
        .pc_inc      (FD_pc_inc),
        .valid       (FD_valid)
    );

endmodule
